fc_acc_argmax: RTL and testbench
================================

FC_ACC_ARGMAX -- requirements
Module: fc_acc_argmax

Interface
REQ-001 SHALL have parameter ACC_W, default 40, width of each signed per-feature product input.
REQ-002 SHALL have parameter SUM_W, default 48, width of each signed class sum and bias; SUM_W >= ACC_W.
REQ-003 SHALL have parameter N_FEAT, default 16, number of products per frame; N_FEAT >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  product triple present.
REQ-007 SHALL have port in_ready  output  1  block accepts a product triple.
REQ-008 SHALL have ports prod0, prod1, prod2  input  ACC_W signed  per-feature products for classes 0..2.
REQ-009 SHALL have ports bias0, bias1, bias2  input  SUM_W signed  per-class bias, quasi-static.
REQ-010 SHALL have port out_valid  output  1  frame result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have ports sum0, sum1, sum2  output  SUM_W signed  biased class sums.
REQ-013 SHALL have port out_class  output  2  argmax index, 0..2.
REQ-014 SHALL have port sat_flag  output  1  at least one saturation in this frame.

Function
REQ-015 SHALL implement FSM with states ACCUM, BIAS, OUT.
REQ-016 SHALL drive in_ready high only in ACCUM and out_valid high only in OUT.
REQ-017 SHALL accept a triple on each rising edge with in_valid && in_ready, adding each sign-extended prodN to sumN.
REQ-018 SHALL keep a feature counter 0..N_FEAT-1, incremented per accepted triple, no wrap within a frame.
REQ-019 SHALL on the accept of the N_FEAT-th triple (edge E) move to BIAS, clear the counter, and drop in_ready after E.
REQ-020 SHALL in BIAS, at edge E+1, add biasN to sumN and move to OUT; out_valid high after E+1; acceptance-to-valid latency is 1 cycle.
REQ-021 SHALL perform every addition (accumulate and bias) with saturation to [-2^(SUM_W-1), 2^(SUM_W-1)-1].
REQ-022 SHALL set sat_flag when any clamp occurs in the frame; it SHALL stay set until the frame is released.
REQ-023 SHALL compute out_class combinationally from the registered sums as the index of the maximum signed sum; ties SHALL resolve to the lowest index.
REQ-024 SHALL hold sum0..2, out_class and sat_flag stable while out_valid && !out_ready.
REQ-025 SHALL on edge with out_valid && out_ready clear sums to 0, clear sat_flag, and return to ACCUM; in_ready high after that edge.
REQ-026 SHALL ignore in_valid in BIAS and OUT; no triple is accepted or lost there because in_ready is low.
REQ-027 SHALL treat in_valid low in ACCUM as a stall with no change to sums or counter.
REQ-028 SHALL with N_FEAT=1 go ACCUM->BIAS on the first accepted triple.
REQ-029 SHALL never assign out_class the value 3.

Reset
REQ-030 SHALL on rst_n low, immediately and regardless of state, set state ACCUM, counter 0, sums 0, sat_flag 0, out_valid 0.
REQ-031 SHALL drive in_ready 1 and out_class 0 while in reset and after release.
REQ-032 SHALL discard a partial frame on reset mid-operation; the next frame starts at feature 0.

Verification
REQ-033 SHALL test N_FEAT=4, biases 0, prods (1,2,3) x4, out_ready=1 -> out_valid one cycle after 4th accept, sums (4,8,12), out_class 2, sat_flag 0.
REQ-034 SHALL test N_FEAT=4, prods (5,-5,5),(5,-5,5),(0,0,0),(0,0,0), bias (0,20,0) -> sums (10,10,10), out_class 0 by tie rule.
REQ-035 SHALL test SUM_W=40, ACC_W=40, N_FEAT=2, prod0 = 2^39-1 twice -> sum0 = 2^39-1, sat_flag 1; next frame after release shows sat_flag 0.
REQ-036 SHALL test in_valid toggling 1,0,1,0 and out_ready held 0 for 5 cycles -> no extra accepts, in_ready 0 throughout OUT, outputs stable until out_ready 1.
REQ-037 SHALL test rst_n pulsed low after 2 of 4 triples -> outputs at reset values at once; a following full frame of (1,1,1) x4 gives sums (4,4,4).

Source files
------------

// File: rtl/fc_acc_argmax.sv
`timescale 1ns/1ps
// fc_acc_argmax: per-frame three-class accumulator with bias add and argmax.
// Accepts N_FEAT product triples, sums each class with saturation, adds a
// per-class bias, then presents the sums, the argmax class and a saturation
// flag until the consumer takes them.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   product triple handshake (prod0..2, ACC_W signed)
//   bias0..2              per-class bias (SUM_W signed), quasi-static
//   out_valid / out_ready result handshake
//   sum0..2               biased class sums (SUM_W signed)
//   out_class             index of the largest sum, lowest index on ties
//   sat_flag              a clamp happened somewhere in this frame
module fc_acc_argmax #(
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned SUM_W  = 48,
  parameter int unsigned N_FEAT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] prod0,
  input  logic signed [ACC_W-1:0] prod1,
  input  logic signed [ACC_W-1:0] prod2,
  input  logic signed [SUM_W-1:0] bias0,
  input  logic signed [SUM_W-1:0] bias1,
  input  logic signed [SUM_W-1:0] bias2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SUM_W-1:0] sum0,
  output logic signed [SUM_W-1:0] sum1,
  output logic signed [SUM_W-1:0] sum2,
  output logic [1:0]              out_class,
  output logic                    sat_flag
);

  localparam int unsigned CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_FEAT - 1);
  localparam logic [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, BIAS, OUT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    accept_c;
  logic                    release_c;
  logic signed [SUM_W-1:0] op     [3];
  logic [SUM_W:0]          add_r  [3];
  logic signed [SUM_W-1:0] best_c;

  // Saturating add; MSB of the result is the clamp indicator.
  function automatic logic [SUM_W:0] sat_add(input logic signed [SUM_W-1:0] a,
                                             input logic signed [SUM_W-1:0] b);
    logic [SUM_W:0] w;
    w = {a[SUM_W-1], a} + {b[SUM_W-1], b};
    if (w[SUM_W] != w[SUM_W-1]) begin
      return {1'b1, (w[SUM_W] ? SUM_MIN : SUM_MAX)};
    end
    return {1'b0, w[SUM_W-1:0]};
  endfunction

  assign accept_c  = in_valid && in_ready;
  assign release_c = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept_c && (cnt == CNT_LAST)) state_nxt = BIAS;
      BIAS:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == ACCUM);
      out_valid <= (state_nxt == OUT);
    end
  end

  // Feature counter; wraps to 0 only on the last feature of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept_c) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Addend is the sign-extended product while accumulating, the bias in BIAS.
  always_comb begin
    op[0] = (state == BIAS) ? bias0 : SUM_W'(prod0);
    op[1] = (state == BIAS) ? bias1 : SUM_W'(prod1);
    op[2] = (state == BIAS) ? bias2 : SUM_W'(prod2);
    add_r[0] = sat_add(sum0, op[0]);
    add_r[1] = sat_add(sum1, op[1]);
    add_r[2] = sat_add(sum2, op[2]);
  end

  // Class sums and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum0     <= '0;
      sum1     <= '0;
      sum2     <= '0;
      sat_flag <= 1'b0;
    end else if (release_c) begin
      sum0     <= '0;
      sum1     <= '0;
      sum2     <= '0;
      sat_flag <= 1'b0;
    end else if (accept_c || (state == BIAS)) begin
      sum0     <= add_r[0][SUM_W-1:0];
      sum1     <= add_r[1][SUM_W-1:0];
      sum2     <= add_r[2][SUM_W-1:0];
      sat_flag <= sat_flag | add_r[0][SUM_W] | add_r[1][SUM_W] | add_r[2][SUM_W];
    end
  end

  // Argmax over the registered sums; strict compare keeps the lowest index on ties.
  always_comb begin
    out_class = 2'd0;
    best_c    = sum0;
    if (sum1 > best_c) begin
      out_class = 2'd1;
      best_c    = sum1;
    end
    if (sum2 > best_c) begin
      out_class = 2'd2;
    end
  end

endmodule

// File: tb/tb_fc_acc_argmax.sv
`timescale 1ns/1ps
// Scoreboard bench for fc_acc_argmax (ACC_W=40, SUM_W=40, N_FEAT=4).
module tb_fc_acc_argmax;

  localparam int unsigned ACC_W  = 40;
  localparam int unsigned SUM_W  = 40;
  localparam int unsigned N_FEAT = 4;
  localparam longint SMAX = (longint'(1) <<< (SUM_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (SUM_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [ACC_W-1:0] prod0 = '0, prod1 = '0, prod2 = '0;
  logic signed [SUM_W-1:0] bias0 = '0, bias1 = '0, bias2 = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [SUM_W-1:0] sum0, sum1, sum2;
  logic [1:0] out_class;
  logic sat_flag;

  fc_acc_argmax #(.ACC_W(ACC_W), .SUM_W(SUM_W), .N_FEAT(N_FEAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .prod0(prod0), .prod1(prod1), .prod2(prod2),
    .bias0(bias0), .bias1(bias1), .bias2(bias2),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum0(sum0), .sum1(sum1), .sum2(sum2),
    .out_class(out_class), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint s0;
    longint s1;
    longint s2;
    int     cls;
    bit     sat;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint fp [N_FEAT][3];
  longint fb [3];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint clampv(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic longint rand40();
    longint r;
    r = longint'({$urandom(), $urandom()});
    return r >>> 24;
  endfunction

  function automatic longint rand_val();
    if ($urandom_range(0, 3) == 0) return rand40();
    return longint'($urandom_range(0, 200)) - 100;
  endfunction

  // Reference: plain saturating arithmetic over the whole frame, then argmax.
  function automatic exp_t model_frame();
    exp_t   e;
    longint s [3];
    longint t;
    longint mx;
    bit     sat;
    sat = 1'b0;
    for (int c = 0; c < 3; c++) s[c] = 0;
    for (int f = 0; f < N_FEAT; f++) begin
      for (int c = 0; c < 3; c++) begin
        t = s[c] + fp[f][c];
        if (clampv(t) != t) sat = 1'b1;
        s[c] = clampv(t);
      end
    end
    for (int c = 0; c < 3; c++) begin
      t = s[c] + fb[c];
      if (clampv(t) != t) sat = 1'b1;
      s[c] = clampv(t);
    end
    mx = s[0];
    for (int c = 1; c < 3; c++) if (s[c] > mx) mx = s[c];
    e.cls = 0;
    for (int c = 2; c >= 0; c--) if (s[c] == mx) e.cls = c;
    e.s0 = s[0];
    e.s1 = s[1];
    e.s2 = s[2];
    e.sat = sat;
    return e;
  endfunction

  // Present one triple and hold it until it is taken; returns at edge+1.
  task automatic send(input longint p0, input longint p1, input longint p2);
    bit r;
    int n;
    in_valid = 1'b1;
    prod0 = ACC_W'(p0);
    prod1 = ACC_W'(p1);
    prod2 = ACC_W'(p2);
    n = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) chk("send_timeout", 0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_sum0"}, longint'(sum0), 0);
    chk({tag, "_sum1"}, longint'(sum1), 0);
    chk({tag, "_sum2"}, longint'(sum2), 0);
    chk({tag, "_class"}, longint'(out_class), 0);
    chk({tag, "_sat"}, longint'(sat_flag), 0);
  endtask

  // Full frame from fp/fb; hold = stall cycles with out_ready low in OUT.
  task automatic run_frame(input int hold, input bit gaps);
    int n;
    sb.push_back(model_frame());
    bias0 = SUM_W'(fb[0]);
    bias1 = SUM_W'(fb[1]);
    bias2 = SUM_W'(fb[2]);
    out_ready = (hold == 0);
    for (int f = 0; f < N_FEAT; f++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send(fp[f][0], fp[f][1], fp[f][2]);
    end
    // Junk stays offered through BIAS/OUT; it must not be taken.
    prod0 = ACC_W'(rand40());
    prod1 = ACC_W'(rand40());
    prod2 = ACC_W'(rand40());
    chk("bias_in_ready", longint'(in_ready), 0);
    chk("bias_out_valid", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("latency_out_valid", longint'(out_valid), 1);
    for (int h = 0; h < hold; h++) begin
      chk("out_in_ready", longint'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (out_valid && n < 20);
    in_valid = 1'b0;
    chk("release_out_valid", longint'(out_valid), 0);
    chk("release_in_ready", longint'(in_ready), 1);
  endtask

  task automatic set_frame(input longint a0, input longint a1, input longint a2);
    for (int f = 0; f < N_FEAT; f++) begin
      fp[f][0] = a0;
      fp[f][1] = a1;
      fp[f][2] = a2;
    end
  endtask

  // Monitor: compare while a result is shown, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=valid required=idle at %0t", $time);
      end else begin
        chk("sum0", longint'(sum0), sb[0].s0);
        chk("sum1", longint'(sum1), sb[0].s1);
        chk("sum2", longint'(sum2), sb[0].s2);
        chk("out_class", longint'(out_class), longint'(sb[0].cls));
        chk("sat_flag", longint'(sat_flag), longint'(sb[0].sat));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    #12;
    check_reset_values("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("after_reset");

    // Plain accumulate, out_ready high.
    set_frame(1, 2, 3);
    fb = '{0, 0, 0};
    run_frame(0, 1'b0);

    // Tie after bias resolves to class 0.
    fp[0] = '{5, -5, 5};
    fp[1] = '{5, -5, 5};
    fp[2] = '{0, 0, 0};
    fp[3] = '{0, 0, 0};
    fb = '{0, 20, 0};
    run_frame(0, 1'b0);

    // Positive saturation, then a clean frame clears sat_flag.
    set_frame(0, 0, 0);
    fp[0][0] = SMAX;
    fp[1][0] = SMAX;
    fb = '{0, 0, 0};
    run_frame(2, 1'b0);
    set_frame(1, 0, -1);
    run_frame(0, 1'b0);

    // Gappy input and a five-cycle consumer stall.
    fp[0] = '{7, -3, 2};
    fp[1] = '{-1, 9, 4};
    fp[2] = '{3, 3, 3};
    fp[3] = '{0, -8, 1};
    fb = '{1, 1, 1};
    run_frame(5, 1'b1);

    // Reset after two of four triples drops the partial frame.
    fb = '{0, 0, 0};
    send(9, 9, 9);
    send(9, 9, 9);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_frame(1, 1, 1);
    run_frame(0, 1'b0);

    // Randomised frames including large operands that saturate both ways.
    for (int k = 0; k < 20; k++) begin
      for (int f = 0; f < N_FEAT; f++)
        for (int c = 0; c < 3; c++) fp[f][c] = rand_val();
      for (int c = 0; c < 3; c++) fb[c] = rand_val();
      run_frame(int'($urandom_range(0, 3)), 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drain", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
